multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the basic processor. Sequences each 9-bit instruction through

---
 rtl/multicycle_sequencer_pkg.sv | 33 +++
 rtl/multicycle_sequencer_sat_counter.sv | 25 ++
 rtl/multicycle_sequencer.sv | 156 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM states, opcodes and
// opcode classification helpers.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [2:0] kST   = 3'b010;
  localparam logic [2:0] kLD   = 3'b011;
  localparam logic [2:0] kHALT = 3'b100;
  localparam logic [2:0] kCMP  = 3'b101;
  localparam logic [2:0] kJ    = 3'b110;
  localparam logic [2:0] kBRE  = 3'b111;

  // R-type covers both 000 and 001.
  function automatic logic is_rtype(input logic [2:0] op);
    return op[2:1] == 2'b00;
  endfunction

  // Instructions that finish with a register write-back.
  function automatic logic needs_wb(input logic [2:0] op);
    return is_rtype(op) || (op == kCMP);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/
// MEM/WB, runs the data-memory req/ack handshake with timeout, keeps counters.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int IW          = 9,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [IW-1:0]    inst,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             branch_en,
  output logic             jump_en,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [2:0] op_reg;
  logic [7:0] tmo_reg, tmo_next;
  logic [2:0] inst_op;
  logic       retire;
  logic       cnt_clr;
  logic       unused_inst_bits;

  assign inst_op          = inst[IW-1 -: 3];
  assign unused_inst_bits = ^inst[IW-4:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= S_IDLE;
      op_reg    <= 3'b000;
      tmo_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      if (state_reg == S_DECODE) begin
        op_reg <= inst_op;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = 8'd0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    branch_en  = 1'b0;
    jump_en    = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    retire     = 1'b0;
    cnt_clr    = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          cnt_clr    = 1'b1;
        end
      end
      S_FETCH: begin
        ir_load    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = (inst_op == kHALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (needs_wb(op_reg)) begin
          state_next = S_WB;
        end else if ((op_reg == kLD) || (op_reg == kST)) begin
          state_next = S_MEM;
        end else begin
          // Control transfer: kJ or kBRE, both retire here.
          pc_en      = 1'b1;
          jump_en    = (op_reg == kJ);
          branch_en  = (op_reg == kBRE) && zero;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_reg == kST);
        // An ack on the last allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          if (op_reg == kST) begin
            pc_en      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (tmo_reg == TMO_LAST) begin
          state_next = S_FAULT;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_en      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_reg != S_IDLE) && (state_reg != S_HALT) && (state_reg != S_FAULT);
  assign halted = (state_reg == S_HALT);
  assign fault  = (state_reg == S_FAULT);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .inc   (busy),
    .count (cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .inc   (retire),
    .count (inst_count)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected cycle traces built from the
// latency rules, random ignored inputs, checked every cycle on two instances.
module tb_multicycle_sequencer;

  localparam logic [2:0] OP_ST = 3'b010, OP_LD = 3'b011, OP_HALT = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101, OP_J = 3'b110, OP_BRE = 3'b111;

  // Expected-output bit masks: {ir_load,pc_en,branch_en,jump_en,reg_we,mem_req,mem_we,busy,halted,fault}
  localparam logic [9:0] M_IR = 10'b1000000000;
  localparam logic [9:0] M_PC = 10'b0100000000;
  localparam logic [9:0] M_BR = 10'b0010000000;
  localparam logic [9:0] M_JP = 10'b0001000000;
  localparam logic [9:0] M_RW = 10'b0000100000;
  localparam logic [9:0] M_MR = 10'b0000010000;
  localparam logic [9:0] M_MW = 10'b0000001000;
  localparam logic [9:0] M_BZ = 10'b0000000100;
  localparam logic [9:0] M_HL = 10'b0000000010;
  localparam logic [9:0] M_FT = 10'b0000000001;

  logic       Clk = 1'b0;
  logic       Reset_n, start, zero, mem_ack;
  logic [8:0] inst;

  logic        ir_load, pc_en, branch_en, jump_en, reg_we, mem_req, mem_we, busy, halted, fault;
  logic [15:0] cycle_count, inst_count;
  logic        s_ir_load, s_pc_en, s_branch_en, s_jump_en, s_reg_we, s_mem_req, s_mem_we;
  logic        s_busy, s_halted, s_fault;
  logic [3:0]  s_cycle_count, s_inst_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cyc = 0;
  int exp_inst = 0;

  always #5 Clk = ~Clk;

  multicycle_sequencer #(.IW(9), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .inst(inst), .zero(zero), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_en(pc_en), .branch_en(branch_en), .jump_en(jump_en),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .halted(halted),
    .fault(fault), .cycle_count(cycle_count), .inst_count(inst_count)
  );

  // Narrow-counter instance sees identical stimulus; used to exercise saturation.
  multicycle_sequencer #(.IW(9), .MEM_TIMEOUT(15), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .inst(inst), .zero(zero), .mem_ack(mem_ack),
    .ir_load(s_ir_load), .pc_en(s_pc_en), .branch_en(s_branch_en), .jump_en(s_jump_en),
    .reg_we(s_reg_we), .mem_req(s_mem_req), .mem_we(s_mem_we), .busy(s_busy), .halted(s_halted),
    .fault(s_fault), .cycle_count(s_cycle_count), .inst_count(s_inst_count)
  );

  function automatic logic [9:0] outs_vec();
    return {ir_load, pc_en, branch_en, jump_en, reg_we, mem_req, mem_we, busy, halted, fault};
  endfunction

  function automatic logic [9:0] s_outs_vec();
    return {s_ir_load, s_pc_en, s_branch_en, s_jump_en, s_reg_we, s_mem_req, s_mem_we,
            s_busy, s_halted, s_fault};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] ro();
    return 3'($urandom);
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cyc(input bit st, input bit z, input bit ack, input logic [2:0] op,
                     input logic [9:0] exp_o, input bit busy_c, input bit ret, input bit clr);
    start   = st;
    zero    = z;
    mem_ack = ack;
    inst    = {op, 6'($urandom)};
    @(negedge Clk);
    chk("outs", int'(outs_vec()), int'(exp_o));
    chk("cycle_count", int'(cycle_count), exp_cyc);
    chk("inst_count", int'(inst_count), exp_inst);
    chk("outs_narrow", int'(s_outs_vec()), int'(exp_o));
    chk("cycle_count_sat", int'(s_cycle_count), sat(exp_cyc, 15));
    chk("inst_count_sat", int'(s_inst_count), sat(exp_inst, 15));
    if (clr) begin
      exp_cyc  = 0;
      exp_inst = 0;
    end else begin
      if (busy_c) exp_cyc = sat(exp_cyc + 1, 65535);
      if (ret)    exp_inst = sat(exp_inst + 1, 65535);
    end
    @(posedge Clk);
    #1;
  endtask

  // Full trace of one instruction from FETCH; w = non-ack MEM cycles before the ack.
  task automatic do_instr(input logic [2:0] op, input bit z, input int w, input bit no_ack);
    logic [9:0] mw;
    mw = (op == OP_ST) ? M_MW : 10'b0;
    cyc(rb(), rb(), rb(), ro(), M_IR | M_BZ, 1, 0, 0);
    cyc(rb(), rb(), rb(), op, M_BZ, 1, 0, 0);
    if (op == OP_HALT) return;
    if (op == OP_J) begin
      cyc(rb(), rb(), rb(), ro(), M_PC | M_JP | M_BZ, 1, 1, 0);
    end else if (op == OP_BRE) begin
      cyc(rb(), z, rb(), ro(), M_PC | (z ? M_BR : 10'b0) | M_BZ, 1, 1, 0);
    end else if (op == OP_LD || op == OP_ST) begin
      cyc(rb(), rb(), rb(), ro(), M_BZ, 1, 0, 0);
      for (int i = 0; i < w; i++) cyc(rb(), rb(), 1'b0, ro(), M_MR | mw | M_BZ, 1, 0, 0);
      if (no_ack) return;
      if (op == OP_ST) begin
        cyc(rb(), rb(), 1'b1, ro(), M_MR | M_MW | M_PC | M_BZ, 1, 1, 0);
      end else begin
        cyc(rb(), rb(), 1'b1, ro(), M_MR | M_BZ, 1, 0, 0);
        cyc(rb(), rb(), rb(), ro(), M_RW | M_PC | M_BZ, 1, 1, 0);
      end
    end else begin
      cyc(rb(), rb(), rb(), ro(), M_BZ, 1, 0, 0);
      cyc(rb(), rb(), rb(), ro(), M_RW | M_PC | M_BZ, 1, 1, 0);
    end
  endtask

  // Sit in HALT for n cycles, then resume with start.
  task automatic halt_seq(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), ro(), M_HL, 0, 0, 0);
    cyc(1'b1, rb(), rb(), ro(), M_HL, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    start = 1'b0; zero = 1'b0; mem_ack = 1'b0; inst = 9'd0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n  = 1'b1;
    exp_cyc  = 0;
    exp_inst = 0;
  endtask

  initial begin
    logic [2:0] op;
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, ro(), 10'b0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, ro(), 10'b0, 0, 0, 1);

    // Directed: R-type, HALT, slow load, fast store, branches, jump.
    do_instr(3'b000, 1'b0, 0, 0);
    chk("lit_rtype_cycles", int'(cycle_count), 4);
    chk("lit_rtype_insts", int'(inst_count), 1);
    do_instr(OP_HALT, 1'b0, 0, 0);
    chk("lit_halted", int'(halted), 1);
    chk("lit_halt_cycles", int'(cycle_count), 6);
    halt_seq(3);
    do_instr(OP_LD, 1'b0, 3, 0);
    chk("lit_ld_cycles", int'(cycle_count), 14);
    chk("lit_ld_insts", int'(inst_count), 2);
    do_instr(OP_ST, 1'b0, 0, 0);
    do_instr(OP_BRE, 1'b1, 0, 0);
    do_instr(OP_BRE, 1'b0, 0, 0);
    do_instr(OP_J, 1'b0, 0, 0);
    do_instr(OP_CMP, 1'b0, 0, 0);
    chk("lit_mix_cycles", int'(cycle_count), 14 + 4 + 3 + 3 + 3 + 4);
    chk("lit_mix_insts", int'(inst_count), 7);

    // Random program.
    for (int k = 0; k < 150; k++) begin
      op = ro();
      do_instr(op, rb(), $urandom_range(0, 14), 0);
      if (op == OP_HALT) halt_seq($urandom_range(0, 2));
    end

    // Ack on the last allowed MEM cycle, then a load that never gets one.
    do_instr(OP_LD, 1'b0, 14, 0);
    do_instr(OP_LD, 1'b0, 15, 1);
    for (int i = 0; i < 4; i++) cyc(1'b1, rb(), rb(), ro(), M_FT, 0, 0, 0);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, ro(), 10'b0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, ro(), 10'b0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, ro(), M_IR | M_BZ, 1, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, OP_LD, M_BZ, 1, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, ro(), M_BZ, 1, 0, 0);
    mem_ack = 1'b0;
    #1;
    chk("mem_req_before_reset", int'(mem_req), 1);
    Reset_n = 1'b0;
    #1;
    chk("outs_async_reset", int'(outs_vec()), 0);
    chk("cycle_count_async_reset", int'(cycle_count), 0);
    @(posedge Clk);
    #1;
    Reset_n  = 1'b1;
    exp_cyc  = 0;
    exp_inst = 0;
    cyc(1'b0, 1'b0, 1'b1, ro(), 10'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
